// File: rtl/dds_core.sv
`default_nettype none
// ============================================================================
// Module      : dds_core
// Description : Phase-accumulator NCO with square, triangle and 1-bit
//               sigma-delta outputs; control inputs are synchronised to clk.
// Revision    : 1.0
// ============================================================================
module dds_core #(
    parameter int                   ACC_WIDTH   = 32,
    parameter int                   OUT_WIDTH   = 8,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [ACC_WIDTH-1:0] RESET_FTW   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 set,
    input  logic [ACC_WIDTH-1:0] m,
    output logic [ACC_WIDTH-1:0] phase,
    output logic                 square,
    output logic [OUT_WIDTH-1:0] triangle,
    output logic                 dac_out,
    output logic                 running
);

    localparam int c_MSB = ACC_WIDTH - 1;

    logic [SYNC_STAGES-1:0] r_en_sync;
    logic [SYNC_STAGES-1:0] r_set_sync;
    logic                   r_set_d;
    logic [ACC_WIDTH-1:0]   r_ftw;
    logic [ACC_WIDTH-1:0]   r_phase;
    logic                   r_square;
    logic [OUT_WIDTH-1:0]   r_triangle;
    logic [OUT_WIDTH:0]     r_sd;
    logic                   r_dac;

    logic                   w_en_s;
    logic                   w_set_s;
    logic                   w_load;
    logic [OUT_WIDTH-1:0]   w_fold;

    assign w_en_s  = r_en_sync[SYNC_STAGES-1];
    assign w_set_s = r_set_sync[SYNC_STAGES-1];
    assign w_load  = w_set_s & ~r_set_d;

    // Mirror the upper half of the phase cycle to get a symmetric triangle.
    assign w_fold = r_phase[c_MSB] ? ~r_phase[c_MSB-1 -: OUT_WIDTH]
                                   :  r_phase[c_MSB-1 -: OUT_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_sync  <= '0;
            r_set_sync <= '0;
            r_set_d    <= 1'b0;
        end else begin
            r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], en};
            r_set_sync <= {r_set_sync[SYNC_STAGES-2:0], set};
            r_set_d    <= w_set_s;
        end
    end

    // A load and an accumulate in the same cycle: the accumulate sees the old ftw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ftw   <= RESET_FTW;
            r_phase <= '0;
        end else begin
            if (w_load) begin
                r_ftw <= m;
            end
            if (w_en_s) begin
                r_phase <= r_phase + r_ftw;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_square   <= 1'b0;
            r_triangle <= '0;
            r_sd       <= '0;
            r_dac      <= 1'b0;
        end else begin
            r_square   <= r_phase[c_MSB];
            r_triangle <= w_fold;
            r_sd       <= {1'b0, r_sd[OUT_WIDTH-1:0]} + {1'b0, r_triangle};
            r_dac      <= r_sd[OUT_WIDTH];
        end
    end

    assign phase    = r_phase;
    assign square   = r_square;
    assign triangle = r_triangle;
    assign dac_out  = r_dac;
    assign running  = w_en_s;

endmodule
`default_nettype wire
